// File: rtl/seg7_pkg.sv
// Shared constants and types for the multiplexed 7-segment scan driver.
// Segment patterns are active-low, bit order g..a.
package seg7_pkg;

  localparam logic [6:0] SEG_OFF = 7'b1111111;

  // Index n holds the pattern for hex digit n.
  localparam logic [15:0][6:0] SEG_HEX = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  typedef enum logic {
    DRIVE,
    BLANK
  } scan_state_e;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low 7-segment decoder (full 0-F range).
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  assign seg_n = SEG_HEX[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed NUM_DIGITS x 7-segment scan driver with double-buffered data,
// per-slot ghost-suppression blank gap, registered outputs.
// Optional macro SEG7_LEADING_ZERO_BLANK_EN blanks leading-zero digits (k>0).
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 2,
  parameter int SCAN_DIV   = 50000,
  parameter int BLANK_CYC  = 1000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic                    load,
  input  logic                    blank_in,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   dig_en,
  output logic                    frame_done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int DW    = 4 * NUM_DIGITS;
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_START = CNT_W'(SCAN_DIV - BLANK_CYC);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NUM_DIGITS - 1);

  scan_state_e           state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DW-1:0]         active_q, active_d;
  logic [DW-1:0]         pending_q, pending_d;
  logic                  pending_valid_q, pending_valid_d;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] dig_en_q, dig_en_d;
  logic                  frame_done_q, frame_done_d;

  logic [3:0] cur_nibble;
  logic [6:0] dec_seg;
  logic       slot_end;
  logic       wrap;
  logic       lz_blank;

  always_comb begin
    cur_nibble = 4'h0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) cur_nibble = active_q[4*k +: 4];
    end
  end

  seg7_hex_decode u_decode (
    .nibble (cur_nibble),
    .seg_n  (dec_seg)
  );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  // Current digit is a leading zero if it and every more significant nibble are zero.
  always_comb begin
    lz_blank = (idx_q != '0);
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (IDX_W'(k) >= idx_q && active_q[4*k +: 4] != 4'h0) lz_blank = 1'b0;
    end
  end
`else
  always_comb begin
    lz_blank = 1'b0;
  end
`endif

  always_comb begin
    slot_end        = (cnt_q == CNT_LAST);
    wrap            = slot_end && (idx_q == IDX_LAST);
    state_d         = state_q;
    cnt_d           = cnt_q + CNT_W'(1);
    idx_d           = idx_q;
    active_d        = active_q;
    pending_d       = pending_q;
    pending_valid_d = pending_valid_q;

    if (slot_end) begin
      cnt_d   = '0;
      state_d = DRIVE;
      idx_d   = wrap ? '0 : idx_q + IDX_W'(1);
    end else if (BLANK_CYC != 0 && cnt_d == BLANK_START) begin
      state_d = BLANK;
    end

    // A load landing on the wrap edge goes straight to the active frame.
    if (wrap) begin
      if (load) begin
        active_d = data_in;
      end else if (pending_valid_q) begin
        active_d = pending_q;
      end
      pending_valid_d = 1'b0;
    end else if (load) begin
      pending_d       = data_in;
      pending_valid_d = 1'b1;
    end

    frame_done_d = wrap;
    seg_d        = SEG_OFF;
    dig_en_d     = '1;
    if (!blank_in && state_q == DRIVE) begin
      seg_d = lz_blank ? SEG_OFF : dec_seg;
      for (int k = 0; k < NUM_DIGITS; k++) begin
        dig_en_d[k] = (idx_q != IDX_W'(k));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= DRIVE;
      cnt_q           <= '0;
      idx_q           <= '0;
      active_q        <= '0;
      pending_q       <= '0;
      pending_valid_q <= 1'b0;
      seg_q           <= SEG_OFF;
      dig_en_q        <= '1;
      frame_done_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      idx_q           <= idx_d;
      active_q        <= active_d;
      pending_q       <= pending_d;
      pending_valid_q <= pending_valid_d;
      seg_q           <= seg_d;
      dig_en_q        <= dig_en_d;
      frame_done_q    <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign dig_en     = dig_en_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: directed steps plus random traffic
// compared each cycle against a time-based reference model.
module tb_seg7_scan_driver;

  localparam int ND = 2;
  localparam int SD = 4;
  localparam int BC = 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [4*ND-1:0] data_in;
  logic          load;
  logic          blank_in;
  logic [6:0]    seg;
  logic [ND-1:0] dig_en;
  logic          frame_done;

  int checks   = 0;
  int failures = 0;

  logic [6:0] hex_table [16];

  // Model: position derived from edges since reset, plus frame buffers.
  int         m_t;
  logic [7:0] m_active;
  logic [7:0] m_pending;
  logic       m_pv;
  logic [6:0] exp_seg;
  logic [1:0] exp_dig;
  logic       exp_fd;
  int         cyc = 0;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .NUM_DIGITS (ND),
    .SCAN_DIV   (SD),
    .BLANK_CYC  (BC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .load       (load),
    .blank_in   (blank_in),
    .seg        (seg),
    .dig_en     (dig_en),
    .frame_done (frame_done)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("[TB] FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, expv);
    end
  endtask

  function automatic bit modelAtWrap();
    return ((m_t % SD) == SD - 1) && (((m_t / SD) % ND) == ND - 1);
  endfunction

  // Drive inputs, take one edge, advance the model, then compare all pins.
  task automatic applyStimulus(input logic rst, input logic ld, input logic [7:0] d, input logic bl);
    int pos;
    int digit;
    logic wrap_now;
    logic [7:0] upper;
    reset    = rst;
    load     = ld;
    data_in  = d;
    blank_in = bl;
    @(posedge clk);
    cyc++;
    if (rst) begin
      exp_seg   = 7'h7F;
      exp_dig   = 2'b11;
      exp_fd    = 1'b0;
      m_t       = 0;
      m_active  = 8'h00;
      m_pending = 8'h00;
      m_pv      = 1'b0;
    end else begin
      pos      = m_t % SD;
      digit    = (m_t / SD) % ND;
      wrap_now = (pos == SD - 1) && (digit == ND - 1);
      exp_fd   = wrap_now;
      if (bl || pos >= SD - BC) begin
        exp_seg = 7'h7F;
        exp_dig = 2'b11;
      end else begin
        exp_dig = 2'b11 & ~(2'b01 << digit);
        upper   = m_active >> (4 * digit);
        exp_seg = hex_table[upper[3:0]];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if (digit > 0 && upper == 8'h00) exp_seg = 7'h7F;
`endif
      end
      if (wrap_now) begin
        if (ld) m_active = d;
        else if (m_pv) m_active = m_pending;
        m_pv = 1'b0;
      end else if (ld) begin
        m_pending = d;
        m_pv      = 1'b1;
      end
      m_t++;
    end
    #1;
    checkOutput("seg", {25'd0, seg}, {25'd0, exp_seg});
    checkOutput("dig_en", {30'd0, dig_en}, {30'd0, exp_dig});
    checkOutput("frame_done", {31'd0, frame_done}, {31'd0, exp_fd});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic waitFrame(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
      seen = frame_done;
    end
    checkOutput(tag, {31'd0, seen}, 32'd1);
  endtask

  task automatic loadAtWrap(input logic [7:0] d);
    for (int i = 0; i < 16 && !modelAtWrap(); i++) idle(1);
    applyStimulus(1'b0, 1'b1, d, 1'b0);
  endtask

  initial begin
    int pulses;
    hex_table = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                  7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                  7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                  7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    m_t = 0; m_active = 8'h00; m_pending = 8'h00; m_pv = 1'b0;

    // Reset held three cycles, then the first DRIVE slot shows digit 0 = 0.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    checkOutput("reset_seg", {25'd0, seg}, 32'h7F);
    checkOutput("reset_dig", {30'd0, dig_en}, 32'h3);
    idle(1);
    checkOutput("first_drive_seg", {25'd0, seg}, {25'd0, 7'b1000000});
    checkOutput("first_drive_dig", {30'd0, dig_en}, 32'h2);

    // Mid-frame load appears only after the next frame boundary.
    idle(2);
    applyStimulus(1'b0, 1'b1, 8'h93, 1'b0);
    waitFrame("wait_frame_93");
    idle(1);
    checkOutput("load93_d0", {25'd0, seg}, {25'd0, 7'b0110000});
    checkOutput("load93_d0_en", {30'd0, dig_en}, 32'h2);
    idle(3);
    idle(1);
    checkOutput("load93_d1", {25'd0, seg}, {25'd0, 7'b0010000});
    checkOutput("load93_d1_en", {30'd0, dig_en}, 32'h1);

    // Last load in a frame wins.
    applyStimulus(1'b0, 1'b1, 8'h12, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'hAF, 1'b0);
    waitFrame("wait_frame_af");
    idle(1);
    checkOutput("last_load_d0", {25'd0, seg}, {25'd0, 7'b0001110});
    idle(4);
    checkOutput("last_load_d1", {25'd0, seg}, {25'd0, 7'b0001000});

    // Load on the wrap edge bypasses the pending buffer.
    loadAtWrap(8'h5C);
    idle(1);
    checkOutput("wrap_load_d0", {25'd0, seg}, {25'd0, 7'b1000110});
    checkOutput("wrap_load_en", {30'd0, dig_en}, 32'h2);

    // Sweep every nibble through digit 0.
    for (int v = 0; v < 16; v++) begin
      loadAtWrap({4'h0, 4'(v)});
      idle(1);
      checkOutput($sformatf("sweep_%0h", v), {25'd0, seg}, {25'd0, hex_table[v]});
    end

    // Blanking keeps the frame cadence: 16 cycles always hold exactly two pulses.
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
      if (frame_done === 1'b1) pulses++;
    end
    checkOutput("blank_frame_pulses", pulses, 32'd2);

    // Mid-slot reset discards pending data.
    idle(1);
    applyStimulus(1'b0, 1'b1, 8'h77, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    idle(1);
    checkOutput("post_reset_d0", {25'd0, seg}, {25'd0, 7'b1000000});
    idle(12);

    // Leading-zero candidates.
    loadAtWrap(8'h05);
    idle(8);
    loadAtWrap(8'h00);
    idle(8);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom % 97) == 0, ($urandom % 5) == 0, 8'($urandom), ($urandom % 8) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
